// File: rtl/hit_pulser.sv
// hit_pulser: turns single-cycle hit events into fixed-width, rate-limited
// output pulses. Hits arriving during a pulse or its trailing gap are counted
// in a small queue and replayed one per pulse/gap period.
module hit_pulser #(
  parameter int CLK_FREQ    = 48000000,
  parameter int PULSE_MS    = 5,
  parameter int GAP_MS      = 10,
  parameter int MAX_PENDING = 7,
  localparam int PW         = $clog2(MAX_PENDING + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          enable,
  input  logic          hit,
  output logic          pulse_out,
  output logic          busy,
  output logic [PW-1:0] pending,
  output logic          overflow
);

  localparam int PULSE_CYCLES = (CLK_FREQ / 1000) * PULSE_MS;
  localparam int GAP_CYCLES   = (CLK_FREQ / 1000) * GAP_MS;
  localparam int MAX_CYCLES   = (PULSE_CYCLES > GAP_CYCLES) ? PULSE_CYCLES : GAP_CYCLES;
  // One shared down-counter; it only ever holds a load value minus one.
  localparam int TW           = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;

  localparam logic [TW-1:0] PULSE_LOAD = TW'(PULSE_CYCLES - 1);
  localparam logic [TW-1:0] GAP_LOAD   = TW'(GAP_CYCLES - 1);
  localparam logic [PW-1:0] PEND_MAX   = PW'(MAX_PENDING);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ON   = 2'd1,
    ST_GAP  = 2'd2
  } state_t;

  state_t        state_q;
  logic [TW-1:0] timer_q;
  logic          pulse_q;
  logic [PW-1:0] pending_q;
  logic          overflow_q;

  logic          hit_acc;
  logic [PW-1:0] pending_eff;
  logic [PW-1:0] pending_d;
  logic          overflow_d;
  logic [PW-1:0] pending_deq_d;

  // A hit only counts while enabled; disabling wipes the queue on the same edge.
  assign hit_acc     = hit & enable;
  assign pending_eff = enable ? pending_q : '0;

  // Queue bookkeeping while a pulse or gap is running (not at a dequeue edge).
  always_comb begin
    pending_d  = pending_eff;
    overflow_d = 1'b0;
    if (hit_acc) begin
      if (pending_q < PEND_MAX) begin
        pending_d = pending_q + PW'(1);
      end else begin
        overflow_d = 1'b1;
      end
    end
  end

  // At the end of a gap a new pulse consumes one queued hit; a hit arriving on
  // that same edge takes the freed slot, so the count stays put.
  always_comb begin
    pending_deq_d = pending_eff;
    if (!hit_acc && (pending_eff != '0)) begin
      pending_deq_d = pending_eff - PW'(1);
    end
  end

  // Pulse FSM with registered drive, queue count and overflow flag.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      timer_q    <= '0;
      pulse_q    <= 1'b0;
      pending_q  <= '0;
      overflow_q <= 1'b0;
    end else begin
      overflow_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          pending_q <= '0;
          pulse_q   <= 1'b0;
          if (hit_acc) begin
            state_q <= ST_ON;
            timer_q <= PULSE_LOAD;
            pulse_q <= 1'b1;
          end
        end
        ST_ON: begin
          pending_q  <= pending_d;
          overflow_q <= overflow_d;
          if (timer_q == '0) begin
            state_q <= ST_GAP;
            timer_q <= GAP_LOAD;
            pulse_q <= 1'b0;
          end else begin
            timer_q <= timer_q - TW'(1);
            pulse_q <= 1'b1;
          end
        end
        ST_GAP: begin
          pulse_q <= 1'b0;
          if (timer_q == '0) begin
            if (hit_acc || (pending_eff != '0)) begin
              state_q   <= ST_ON;
              timer_q   <= PULSE_LOAD;
              pulse_q   <= 1'b1;
              pending_q <= pending_deq_d;
            end else begin
              state_q   <= ST_IDLE;
              pending_q <= '0;
            end
          end else begin
            timer_q    <= timer_q - TW'(1);
            pending_q  <= pending_d;
            overflow_q <= overflow_d;
          end
        end
        default: begin
          state_q   <= ST_IDLE;
          timer_q   <= '0;
          pulse_q   <= 1'b0;
          pending_q <= '0;
        end
      endcase
    end
  end

  assign busy      = (state_q != ST_IDLE);
  assign pulse_out = pulse_q;
  assign pending   = pending_q;
  assign overflow  = overflow_q;

endmodule

// File: tb/tb_hit_pulser.sv
// tb_hit_pulser: directed scenarios plus random hits/enable/reset, compared
// every cycle against a timeline-based reference model.
module tb_hit_pulser;

  localparam int P   = 3;
  localparam int G   = 2;
  localparam int MAXP = 2;
  localparam int PW  = $clog2(MAXP + 1);

  logic          clk;
  logic          reset;
  logic          enable;
  logic          hit;
  logic          pulse_out;
  logic          busy;
  logic [PW-1:0] pending;
  logic          overflow;

  int n_checks;
  int n_pass;

  // Reference model: a pulse is described by the edge index where it began;
  // its phase (edges since start) tells whether it is high, in the gap, or
  // at its decision edge.
  int m_edge;
  int m_active;
  int m_start;
  int m_pend;
  int m_ovf;

  hit_pulser #(
    .CLK_FREQ   (1000),
    .PULSE_MS   (P),
    .GAP_MS     (G),
    .MAX_PENDING(MAXP)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .enable   (enable),
    .hit      (hit),
    .pulse_out(pulse_out),
    .busy     (busy),
    .pending  (pending),
    .overflow (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s at edge %0d: got %0d expected %0d", tag, m_edge, got, exp);
  endtask

  task automatic model_edge(input int h, input int e, input int r);
    int hv;
    int total;
    m_edge++;
    hv = h & e;
    if (r == 0) begin
      m_active = 0;
      m_pend   = 0;
      m_ovf    = 0;
    end else if (m_active == 0) begin
      m_ovf  = 0;
      m_pend = 0;
      if (hv != 0) begin
        m_active = 1;
        m_start  = m_edge;
      end
    end else if (m_edge - m_start == P + G) begin
      m_ovf = 0;
      total = (e != 0 ? m_pend : 0) + hv;
      if (total > 0) begin
        m_start = m_edge;
        m_pend  = total - 1;
      end else begin
        m_active = 0;
        m_pend   = 0;
      end
    end else begin
      m_ovf = 0;
      if (e == 0) m_pend = 0;
      else if (hv != 0) begin
        if (m_pend < MAXP) m_pend++;
        else m_ovf = 1;
      end
    end
  endtask

  task automatic step(input logic h, input logic e, input logic r);
    int exp_pulse;
    hit    = h;
    enable = e;
    reset  = r;
    @(posedge clk);
    model_edge(int'(h), int'(e), int'(r));
    @(negedge clk);
    exp_pulse = (m_active != 0 && (m_edge - m_start) < P) ? 1 : 0;
    check("pulse_out", int'(pulse_out), exp_pulse);
    check("busy", int'(busy), m_active);
    check("pending", int'(pending), m_pend);
    check("overflow", int'(overflow), m_ovf);
    $display("edge %0d hit=%0b en=%0b rst=%0b -> pulse=%0b busy=%0b pend=%0d ovf=%0b",
             m_edge, h, e, r, pulse_out, busy, pending, overflow);
  endtask

  task automatic idle(input int cycles);
    for (int i = 0; i < cycles; i++) step(1'b0, 1'b1, 1'b1);
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    m_edge   = 0;
    m_active = 0;
    m_start  = 0;
    m_pend   = 0;
    m_ovf    = 0;
    hit      = 1'b0;
    enable   = 1'b1;
    reset    = 1'b0;

    // Reset held, then released with no hits.
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0);
    idle(3);

    // Single hit.
    step(1'b1, 1'b1, 1'b1);
    idle(8);

    // Three back-to-back hits: two get queued.
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b1);
    idle(16);

    // Four hits: the fourth overflows.
    for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 1'b1);
    idle(18);

    // Hit on the final gap edge while the queue is full.
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b1);
    idle(2);
    step(1'b1, 1'b1, 1'b1);
    idle(20);

    // Reset in the middle of a pulse.
    step(1'b1, 1'b1, 1'b1);
    idle(1);
    step(1'b0, 1'b1, 1'b0);
    idle(6);

    // Enable dropped during the gap with a full queue.
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b1);
    step(1'b0, 1'b1, 1'b1);
    step(1'b1, 1'b0, 1'b1);
    idle(10);

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      step(logic'(($urandom % 3) == 0),
           logic'(($urandom % 16) != 0),
           logic'(($urandom % 64) != 0));
    end
    idle(12);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
